// File: rtl/cdc_sync_pkg.sv
// Shared types and sizes for the mux select arbiter and its round-robin picker.
package cdc_sync_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        VALID  = 2'd2
    } arb_state_t;

    function automatic logic [NUM_CH-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_CH'(1) << idx;
    endfunction

endpackage

// File: rtl/mux_sel_arbiter_if.sv
// Request/grant/select handshake between the requesters, the arbiter and the mux consumer.
interface mux_sel_arbiter_if;
    import cdc_sync_pkg::*;

    logic [NUM_CH-1:0] req;
    logic [NUM_CH-1:0] gnt;
    logic [SEL_W-1:0]  sel;
    logic              out_valid;
    logic              out_ready;
    logic              busy;

    modport master (
        output req, out_ready,
        input  gnt, sel, out_valid, busy
    );

    modport slave (
        input  req, out_ready,
        output gnt, sel, out_valid, busy
    );

endinterface

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: first set request scanning ptr, ptr+1, .. mod 4.
module rr_pick_4
    import cdc_sync_pkg::*;
(
    input  logic [NUM_CH-1:0] req_i,
    input  logic [SEL_W-1:0]  ptr_i,
    output logic              any_o,
    output logic [SEL_W-1:0]  idx_o
);

    logic [SEL_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is the last write.
    always_comb begin
        any_o = |req_i;
        idx_o = ptr_i;
        cand  = ptr_i;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            cand = ptr_i + SEL_W'(k);
            if (req_i[cand]) idx_o = cand;
        end
    end

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving a registered mux select, held for a settle window
// before out_valid, and released by a valid/ready handshake.
module mux_sel_arbiter
    import cdc_sync_pkg::*;
#(
    parameter int HOLD_CYCLES = 2
) (
    input  logic               clk,
    input  logic               rst,
    mux_sel_arbiter_if.slave   bus
);

    localparam int CNT_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT =
        (HOLD_CYCLES > 0) ? CNT_W'(HOLD_CYCLES - 1) : '0;

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SEL_W-1:0]  ptr_q, ptr_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic              valid_q, valid_d;

    logic              pick_any;
    logic [SEL_W-1:0]  pick_idx;

    rr_pick_4 u_pick (
        .req_i (bus.req),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            sel_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
        end
    end

    // Requests are only looked at in IDLE, so a granted channel keeps sel/gnt
    // until the consumer accepts, whatever req does meanwhile.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    gnt_d = onehot(pick_idx);
                    sel_d = pick_idx;
                    if (HOLD_CYCLES > 0) begin
                        state_d = SETTLE;
                        cnt_d   = CNT_INIT;
                    end else begin
                        state_d = VALID;
                        valid_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = VALID;
                    valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            VALID: begin
                if (valid_q && bus.out_ready) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    valid_d = 1'b0;
                    ptr_d   = sel_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.gnt       = gnt_q;
    assign bus.sel       = sel_q;
    assign bus.out_valid = valid_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Randomized + directed bench for two arbiter instances (HOLD_CYCLES=2 and 0)
// checked cycle by cycle against a transfer-level reference model via a scoreboard.
module tb_mux_sel_arbiter;
    import cdc_sync_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux_sel_arbiter_if if_h2 ();
    mux_sel_arbiter_if if_h0 ();

    mux_sel_arbiter #(.HOLD_CYCLES(2)) dut_h2 (.clk(clk), .rst(rst), .bus(if_h2.slave));
    mux_sel_arbiter #(.HOLD_CYCLES(0)) dut_h0 (.clk(clk), .rst(rst), .bus(if_h0.slave));

    typedef struct packed {
        logic [1:0][3:0] gnt;
        logic [1:0][1:0] sel;
        logic [1:0]      vld;
        logic [1:0]      busy;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: owner channel (-1 = none) and edges elapsed since its grant.
    int hold_of [2] = '{2, 0};
    int m_owner [2];
    int m_age   [2];
    int m_ptr   [2];
    int m_sel   [2];

    task automatic model_step(input int k, input logic r, input logic [3:0] q, input logic rdy);
        if (r) begin
            m_owner[k] = -1; m_age[k] = 0; m_ptr[k] = 0; m_sel[k] = 0;
        end else if (m_owner[k] < 0) begin
            for (int i = 0; i < 4; i++) begin
                int c;
                c = (m_ptr[k] + i) % 4;
                if (q[c] && m_owner[k] < 0) m_owner[k] = c;
            end
            if (m_owner[k] >= 0) begin
                m_sel[k] = m_owner[k];
                m_age[k] = 0;
            end
        end else if (m_age[k] >= hold_of[k] && rdy) begin
            m_ptr[k]   = (m_owner[k] + 1) % 4;
            m_owner[k] = -1;
        end else if (m_age[k] < hold_of[k]) begin
            m_age[k]++;
        end
    endtask

    task automatic cycle(input logic r, input logic [3:0] q, input logic rdy);
        exp_t e;
        @(negedge clk);
        rst = r;
        if_h2.req = q;  if_h0.req = q;
        if_h2.out_ready = rdy;  if_h0.out_ready = rdy;
        for (int k = 0; k < 2; k++) begin
            model_step(k, r, q, rdy);
            e.gnt[k]  = (m_owner[k] >= 0) ? (4'b0001 << m_owner[k]) : 4'b0000;
            e.sel[k]  = 2'(m_sel[k]);
            e.vld[k]  = (m_owner[k] >= 0) && (m_age[k] >= hold_of[k]);
            e.busy[k] = (m_owner[k] >= 0);
        end
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input int k, input logic [3:0] got, input logic [3:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s hold=%0d t=%0t: got %h expected %h", name, hold_of[k], $time, got, want);
        end
    endtask

    // Monitor: compare every registered output just after each edge.
    exp_t mon_e;
    always @(posedge clk) begin
        #1;
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            chk("gnt",       0, if_h2.gnt,              mon_e.gnt[0]);
            chk("sel",       0, {2'b0, if_h2.sel},      {2'b0, mon_e.sel[0]});
            chk("out_valid", 0, {3'b0, if_h2.out_valid}, {3'b0, mon_e.vld[0]});
            chk("busy",      0, {3'b0, if_h2.busy},     {3'b0, mon_e.busy[0]});
            chk("gnt",       1, if_h0.gnt,              mon_e.gnt[1]);
            chk("sel",       1, {2'b0, if_h0.sel},      {2'b0, mon_e.sel[1]});
            chk("out_valid", 1, {3'b0, if_h0.out_valid}, {3'b0, mon_e.vld[1]});
            chk("busy",      1, {3'b0, if_h0.busy},     {3'b0, mon_e.busy[1]});
        end
    end

    initial begin
        if_h2.req = '0;  if_h0.req = '0;
        if_h2.out_ready = 1'b0;  if_h0.out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_owner[k] = -1; m_age[k] = 0; m_ptr[k] = 0; m_sel[k] = 0;
        end

        // Reset with all requests asserted
        cycle(1'b1, 4'b1111, 1'b0);
        cycle(1'b1, 4'b1111, 1'b0);

        // Single request, settle, accept, then ptr moves past ch2
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0100, 1'b0);
        cycle(1'b0, 4'b0100, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b1111, 1'b0);
        cycle(1'b0, 4'b1111, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);

        // Fairness under constant full request
        cycle(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 24; i++) cycle(1'b0, 4'b1111, 1'b1);

        // Backpressure with req churn while held
        cycle(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 4'b1010, 1'b0);
        for (int i = 0; i < 5; i++) cycle(1'b0, 4'($urandom), 1'b0);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b1);

        // Reset in the middle of a settle window
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0100, 1'b0);
        cycle(1'b1, 4'b0100, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b1111, 1'b0);

        // Grant dropping its request before accept
        cycle(1'b1, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0010, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b0, 4'b0000, 1'b0);
        cycle(1'b0, 4'b0000, 1'b1);
        cycle(1'b0, 4'b0000, 1'b0);

        // Random traffic with occasional resets
        for (int i = 0; i < 500; i++)
            cycle($urandom_range(0, 59) == 0, 4'($urandom), $urandom_range(0, 2) != 0);

        @(negedge clk);
        @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
